ro_sampler_ctrl: RTL

RO_SAMPLER_CTRL -- requirements
Module: ro_sampler_ctrl

---
 rtl/ro_sampler_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ro_sampler_ctrl.sv
// Ring-oscillator entropy sampler: seeds, settles and free-runs NUM_LOOPS loops, then
// collects 32 XOR-combined samples into a word handed off with a valid/ack handshake.
module ro_sampler_ctrl #(
    parameter int unsigned NUM_LOOPS     = 4,
    parameter int unsigned SEED_CYCLES   = 16,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned SAMPLE_DIV    = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    output logic [NUM_LOOPS-1:0] loop_ctrl_o,
    output logic                 loop_seed_o,
    input  logic [NUM_LOOPS-1:0] loop_d_i,
    output logic [31:0]          data_o,
    output logic                 valid_o,
    input  logic                 ack_i,
    output logic                 busy_o
);

    typedef enum logic [2:0] {
        StIdle,
        StSeed,
        StSettle,
        StCollect,
        StHold
    } state_e;

    // Phase counter is wide enough for the largest SETTLE_CYCLES, divider for SAMPLE_DIV.
    localparam logic [9:0] SeedLast   = 10'(SEED_CYCLES - 1);
    localparam logic [9:0] SettleLast = 10'(SETTLE_CYCLES - 1);
    localparam logic [7:0] DivLast    = 8'(SAMPLE_DIV - 1);

    state_e                state_q, state_d;
    logic [9:0]            phase_cnt_q, phase_cnt_d;
    logic [7:0]            div_cnt_q, div_cnt_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [31:0]           shift_q, shift_d;
    logic [31:0]           data_q, data_d;
    logic                  valid_q, valid_d;
    logic [NUM_LOOPS-1:0]  sync1_q, sync2_q;
    logic                  sample_bit;

    assign sample_bit = ^sync2_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (enable_i) state_d = StSeed;
            end
            StSeed: begin
                if (!enable_i)                  state_d = StIdle;
                else if (phase_cnt_q == SeedLast) state_d = StSettle;
            end
            StSettle: begin
                if (!enable_i)                    state_d = StIdle;
                else if (phase_cnt_q == SettleLast) state_d = StCollect;
            end
            StCollect: begin
                if (!enable_i)                                   state_d = StIdle;
                else if (div_cnt_q == DivLast && bit_cnt_q == 5'd31) state_d = StHold;
            end
            StHold: begin
                // enable is deliberately ignored here: the word waits for ack.
                if (ack_i) state_d = enable_i ? StSeed : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        loop_ctrl_o = '1;
        loop_seed_o = 1'b0;
        if (state_q == StSettle || state_q == StCollect) loop_ctrl_o = '0;
        if (state_q == StSeed) loop_seed_o = 1'b1;
        busy_o  = (state_q != StIdle);
        data_o  = data_q;
        valid_o = valid_q;
    end

    always_comb begin
        phase_cnt_d = phase_cnt_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        unique case (state_q)
            StSeed, StSettle: phase_cnt_d = phase_cnt_q + 10'd1;
            StCollect: begin
                if (div_cnt_q == DivLast) begin
                    div_cnt_d = 8'd0;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    shift_d   = {shift_q[30:0], sample_bit};
                    if (bit_cnt_q == 5'd31 && enable_i) begin
                        data_d  = {shift_q[30:0], sample_bit};
                        valid_d = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            StHold: begin
                if (ack_i) valid_d = 1'b0;
            end
            default: ;
        endcase
        // Every phase starts from clean counters; an aborted word leaves nothing behind.
        if (state_d != state_q) begin
            phase_cnt_d = 10'd0;
            div_cnt_d   = 8'd0;
            bit_cnt_d   = 5'd0;
            shift_d     = 32'd0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            phase_cnt_q <= 10'd0;
            div_cnt_q   <= 8'd0;
            bit_cnt_q   <= 5'd0;
            shift_q     <= 32'd0;
            data_q      <= 32'd0;
            valid_q     <= 1'b0;
            sync1_q     <= '0;
            sync2_q     <= '0;
        end else begin
            phase_cnt_q <= phase_cnt_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sync1_q     <= loop_d_i;
            sync2_q     <= sync1_q;
        end
    end

endmodule
